imem_fetch_ctrl: RTL
====================

// Module: imem_fetch_ctrl
// PURPOSE
//  Sequencer for the single-port 32x16 instruction memory. In LOAD mode it streams a program
//  into the memory through a valid/ready loader port (InsMemRW=1). In RUN mode it owns the PC,
//  drives IAddress (InsMemRW=0) and registers each fetched word into an IR. It then presents
//  op/rs/rt/imm to the decoder under a valid/ready handshake, with branch redirect and halt.
// PARAMETERS
//  DEPTH    32       instruction words; address wraps at DEPTH-1 -> 0
//  AW       16       IAddress width
//  HALT_OP  4'b1111  opcode that stops fetching
// PORTS
//  CLK         in   1   clock, rising edge
//  Reset       in   1   synchronous, active-low reset
//  load_start  in   1   pulse: enter LOAD, write pointer <- 0
//  ld_valid    in   1   loader word valid
//  ld_ready    out  1   controller accepts loader word
//  ld_data     in   16  loader word
//  ld_last     in   1   qualifies the final loader word
//  run_start   in   1   pulse: enter RUN, PC <- 0
//  mem_rdata   in   16  combinational read data for IAddress
//  InsMemRW    out  1   1 = write, 0 = read
//  IAddress    out  AW  memory address (write pointer or PC)
//  IData       out  16  write data (= ld_data)
//  ins_valid   out  1   IR holds a valid instruction
//  ins_ready   in   1   decoder consumes IR
//  op,rs,rt,imm out 4 each  IR[3:0],[7:4],[11:8],[15:12]
//  br_valid    in   1   redirect request
//  br_addr     in   AW  redirect target
//  halted      out  1   HALT_OP reached the IR
// BEHAVIOUR
//  Reset (Reset==0 at an edge): state=IDLE; PC=0; wptr=0; IR=0; all outputs 0. Any state aborts.
//  States: IDLE, LOAD, RUN, HALT.
//  IDLE: load_start -> LOAD. run_start -> RUN. If both are asserted, load_start wins.
//  LOAD: ld_ready=1, InsMemRW=1, IAddress=wptr, IData=ld_data.
//   Each ld_valid&ld_ready edge writes one word and increments wptr.
//   ld_last accepted, or wptr==DEPTH-1 accepted -> IDLE; wptr is then reset to 0.
//   Words beyond DEPTH are never written. run_start is ignored in LOAD.
//  RUN: InsMemRW=0, IAddress=PC. Fetch latency: address in cycle n -> IR/ins_valid at edge n+1.
//   IR load: when ins_valid==0 or (ins_valid&ins_ready):
//    IR<=mem_rdata, ins_valid<=1, PC<=PC+1 (wrap at DEPTH).
//   Otherwise: IR, PC, ins_valid hold (decoder stall).
//   br_valid has priority over a fetch:
//    PC<=br_addr mod DEPTH; ins_valid<=0 (flush); IR keeps its value.
//    The next cycle fetches the target.
//   IR loaded with op==HALT_OP: that word is still presented (ins_valid=1).
//    State -> HALT; PC is frozen at the word after the halt.
//  HALT: halted=1. IR is held until consumed, then ins_valid=0. br_valid is ignored.
//   load_start -> LOAD (halted=0). run_start -> RUN with PC=0 (halted=0).
//  load_start/run_start in RUN: load_start -> LOAD with ins_valid=0; run_start restarts PC at 0.
//  InsMemRW=1 only in LOAD. The fetch path never sees a write-cycle address.
// STRUCTURE
//  Package imem_pkg: state enum {IDLE,LOAD,RUN,HALT}, DEPTH, HALT_OP, field bit positions.
//  Sub-module imem_pc_counter: modulo-DEPTH counter with clear, load (br_addr) and increment.
//   One instance is used as PC and one as wptr.
//  Top: FSM, IR register, address/RW mux.
// TESTING
//  1. Load 4 words (0x1234, 0x5678, 0x9ABC, 0x000F with ld_last):
//     expect 4 writes at addresses 0..3, InsMemRW=1, then IDLE with ld_ready=0.
//  2. run_start with ins_ready=1: IAddress 0,1,2,3 on consecutive cycles.
//     IR 0x1234 gives op=4 rs=3 rt=2 imm=1. Word 3 (op=F) sets halted=1; PC frozen at 4.
//  3. Hold ins_ready=0 for 3 cycles mid-run: IR, PC and ins_valid stable.
//     Release: resumes with no word lost or duplicated.
//  4. br_valid with br_addr=0x0022 at PC=5: ins_valid drops for 1 cycle, next IAddress=2.
//     Fetch and br_valid in the same cycle: br_valid wins.
//  5. Load 40 words without ld_last: exactly 32 writes, wptr wraps to 0, state returns to IDLE.
//  6. Assert Reset low during LOAD and during RUN: next edge IDLE, all outputs 0.
//     Asynchronous assertion between edges has no effect until the next edge.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared constants, state encoding and address-wrap helper for the instruction-memory sequencer.
package imem_pkg;
  localparam int DEPTH = 32;
  localparam int AW = 16;
  localparam logic [3:0] HALT_OP = 4'b1111;

  localparam int FIELD_W = 4;
  localparam int OP_LSB = 0;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 8;
  localparam int IMM_LSB = 12;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a);
    return a % AW'(DEPTH);
  endfunction
endpackage

// File: rtl/imem_fetch_ctrl_pc_counter.sv
// Modulo-DEPTH address counter: clear beats load beats increment.
module imem_pc_counter
  import imem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= wrap_addr(load_val);
    end else if (inc) begin
      count <= (count == AW'(DEPTH - 1)) ? '0 : count + AW'(1);
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Loads a program into the single-port instruction memory, then fetches it into an IR with
// one-cycle read latency; the decoder stalls via ins_ready, branches flush the IR valid.
module imem_fetch_ctrl
  import imem_pkg::*;
(
  input  logic          CLK,
  input  logic          Reset,
  input  logic          load_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [15:0]   ld_data,
  input  logic          ld_last,
  input  logic          run_start,
  input  logic [15:0]   mem_rdata,
  output logic          InsMemRW,
  output logic [AW-1:0] IAddress,
  output logic [15:0]   IData,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [3:0]    op,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [3:0]    imm,
  input  logic          br_valid,
  input  logic [AW-1:0] br_addr,
  output logic          halted
);

  state_t        state;
  logic [15:0]   ir;
  logic [AW-1:0] pc;
  logic [AW-1:0] wptr;

  logic in_load, in_run, in_halt;
  logic fetch_ok, ld_fire, ld_done;
  logic pc_clear, pc_load, pc_inc;
  logic wp_clear, wp_inc;

  assign in_load  = (state == LOAD);
  assign in_run   = (state == RUN);
  assign in_halt  = (state == HALT);
  assign fetch_ok = !ins_valid || ins_ready;

  // A fresh load_start inside LOAD restarts the pointer instead of writing.
  assign ld_fire  = in_load && ld_valid && !load_start;
  assign ld_done  = ld_fire && (ld_last || (wptr == AW'(DEPTH - 1)));

  assign pc_clear = run_start && !load_start && !in_load;
  assign pc_load  = in_run && !load_start && !run_start && br_valid;
  assign pc_inc   = in_run && !load_start && !run_start && !br_valid && fetch_ok;
  assign wp_clear = load_start || ld_done;
  assign wp_inc   = ld_fire && !ld_done;

  imem_pc_counter u_pc (
    .clk      (CLK),
    .rst_n    (Reset),
    .clear    (pc_clear),
    .load     (pc_load),
    .load_val (br_addr),
    .inc      (pc_inc),
    .count    (pc)
  );

  imem_pc_counter u_wptr (
    .clk      (CLK),
    .rst_n    (Reset),
    .clear    (wp_clear),
    .load     (1'b0),
    .load_val ('0),
    .inc      (wp_inc),
    .count    (wptr)
  );

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state     <= IDLE;
      ir        <= '0;
      ins_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start)     state <= LOAD;
          else if (run_start) state <= RUN;
        end
        LOAD: begin
          if (ld_done) state <= IDLE;
        end
        RUN: begin
          if (load_start) begin
            state     <= LOAD;
            ins_valid <= 1'b0;
          end else if (run_start || br_valid) begin
            ins_valid <= 1'b0;
          end else if (fetch_ok) begin
            ir        <= mem_rdata;
            ins_valid <= 1'b1;
            if (mem_rdata[OP_LSB +: FIELD_W] == HALT_OP) state <= HALT;
          end
        end
        HALT: begin
          if (load_start) begin
            state     <= LOAD;
            ins_valid <= 1'b0;
          end else if (run_start) begin
            state     <= RUN;
            ins_valid <= 1'b0;
          end else if (ins_valid && ins_ready) begin
            ins_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address is driven only while a mode owns the memory port; IDLE parks it at 0.
  assign ld_ready = in_load;
  assign InsMemRW = in_load;
  assign IAddress = in_load ? wptr : ((in_run || in_halt) ? pc : '0);
  assign IData    = in_load ? ld_data : '0;
  assign halted   = in_halt;

  assign op  = ir[OP_LSB  +: FIELD_W];
  assign rs  = ir[RS_LSB  +: FIELD_W];
  assign rt  = ir[RT_LSB  +: FIELD_W];
  assign imm = ir[IMM_LSB +: FIELD_W];

endmodule
